// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes a Johnson-coded stream to a phase index, tracks lock and counts errors
module johnson_decoder #(
    parameter int N        = 4,
    parameter int IDXW     = 3,
    parameter int LOCK_CNT = 3,
    parameter int ERRW     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            code_valid,
    input  logic [N-1:0]    code_in,
    input  logic            clear_err,
    output logic [IDXW-1:0] idx,
    output logic            idx_valid,
    output logic            illegal,
    output logic            seq_err,
    output logic            locked,
    output logic [ERRW-1:0] err_count
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
    localparam logic [IDXW:0] TWO_N = (IDXW + 1)'(2 * N);
    localparam logic [IDXW-1:0] LAST = IDXW'(2 * N - 1);

    typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

    state_t          state;
    logic [IDXW-1:0] ref_idx, index, succ, pc;
    logic [GW-1:0]   good_cnt, good_nxt;
    logic [N-1:0]    w;
    logic            legal, err_ev;

    // legality, phase index and the expected successor of the reference phase
    always_comb begin
        w = code_in[N-1] ? ~code_in : code_in;
        legal = (w & (w + N'(1))) == '0;
        pc = '0;
        for (int i = 0; i < N; i++) pc = pc + IDXW'(code_in[i]);
        index = code_in[N-1] ? IDXW'(TWO_N - {1'b0, pc}) : pc;
        succ = (ref_idx == LAST) ? '0 : ref_idx + IDXW'(1);
        good_nxt = good_cnt + GW'(1);
        err_ev = code_valid && state == LOCKED && (!legal || (index != succ && index != ref_idx));
    end

    assign locked = (state == LOCKED);

    // lock FSM with registered decode outputs and saturating error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            ref_idx   <= '0;
            good_cnt  <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            err_count <= '0;
        end else begin
            idx_valid <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            err_count <= clear_err ? '0 : (err_ev && !(&err_count)) ? err_count + ERRW'(1) : err_count;
            if (code_valid) begin
                if (!legal) begin
                    illegal <= 1'b1;
                    state   <= HUNT;
                end else begin
                    idx       <= index;
                    idx_valid <= 1'b1;
                    ref_idx   <= index;
                    if (state == HUNT) begin
                        state    <= TRACK;
                        good_cnt <= '0;
                    end else if (index == succ) begin
                        if (state == TRACK) begin
                            good_cnt <= good_nxt;
                            if (good_nxt == LOCK_V) state <= LOCKED;
                        end
                    end else if (index != ref_idx) begin
                        seq_err  <= (state == LOCKED);
                        good_cnt <= '0;
                        state    <= TRACK;
                    end
                end
            end
        end
    end
endmodule

// File: doc/johnson_decoder.md
Name: johnson_decoder

Overview:
Receive-side companion to the team's Johnson counter. Samples an N-bit Johnson-coded word on each valid cycle and decodes it to a binary phase index. Checks that the stream follows the legal Johnson sequence: 0000→0001→0011→0111→1111→1110→1100→1000→0000 for N=4. Tracks lock and counts errors, so downstream logic can trust or reject the phase.

Parameters:
N, 4, Johnson code width; sequence length is 2N
IDXW, 3, index width, clog2(2N)
LOCK_CNT, 3, consecutive correct successor transitions required to reach LOCKED
ERRW, 8, error counter width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
code_valid  input  1  code_in is sampled this cycle
code_in  input  N  Johnson-coded word
clear_err  input  1  synchronous clear of err_count
idx  output  IDXW  decoded phase index of last legal sampled code
idx_valid  output  1  one-cycle pulse: idx updated from a legal code
illegal  output  1  one-cycle pulse: sampled code is not a legal Johnson word
seq_err  output  1  one-cycle pulse: legal code, but not successor or repeat, while LOCKED
locked  output  1  high while FSM is in LOCKED
err_count  output  ERRW  saturating count of illegal and seq_err events

Behaviour:
- Reset (synchronous, active-high): state=HUNT, ref_idx=0, good_cnt=0, idx=0, all pulses 0, locked=0, err_count=0. Reset mid-stream discards the reference; the next valid code restarts in HUNT.
- Legality:
  - msb=0: legal iff code has contiguous ones from the LSB, i.e. (code & (code+1))==0.
  - msb=1: legal iff ~code satisfies the same test.
- Decode: pc = popcount(code_in); index = msb ? (2N−pc) mod 2N : pc. For N=4: 0000→0, 0111→3, 1111→4, 1110→5, 1000→7.
- Latency: all outputs are registered. A code sampled at edge t produces outputs visible after edge t+1. Pulses last exactly one cycle.
- code_valid=0: no state change, no pulses.
- Successor check: succ = (ref_idx+1) mod 2N; wrap from 2N−1 to 0 is legal.
- Repeat: a legal code with index == ref_idx is a hold (source counter stalled). Effects: idx_valid=1, no progress, no error, in every state.
- FSM, evaluated on code_valid=1:
  - HUNT:
    - legal → ref_idx=index, good_cnt=0, go TRACK.
    - illegal → illegal pulse, stay HUNT, err_count unchanged (not yet locked).
  - TRACK:
    - legal successor → good_cnt+1; if good_cnt+1==LOCK_CNT go LOCKED.
    - legal non-successor → ref_idx=index, good_cnt=0, stay TRACK, no seq_err.
    - illegal → illegal pulse, go HUNT, err_count unchanged.
  - LOCKED:
    - legal successor → stay.
    - legal non-successor → seq_err pulse, err_count+1, ref_idx=index, good_cnt=0, go TRACK.
    - illegal → illegal pulse, err_count+1, go HUNT.
- ref_idx/idx update on every legal sample; idx holds its value on illegal samples.
- err_count saturates at 2^ERRW−1, no wrap.
- clear_err has priority: an error event in the same cycle still pulses, but err_count becomes 0.
- locked deasserts in the same output cycle as the seq_err/illegal pulse that causes the exit.

Test Plan:
- Lock-up: reset, then drive codes 0000,0001,0011,0111,… one per cycle with code_valid=1 → idx=0,1,2,3,… with idx_valid each cycle. locked=1 in the output cycle of the 4th code (0111), err_count=0.
- Wrap: while locked, drive 1100,1000,0000,0001 → idx 6,7,0,1; locked stays 1; no seq_err.
- Hold and gap: while locked, drive 0111 three times, then code_valid=0 for 2 cycles, then 1111 → idx=3 held, idx=4 after; no errors; locked stays 1.
- Skip: while locked at idx=1 (0001), drive 0111 → seq_err=1 for one cycle, err_count=1, locked=0. Next drive 1111,1110,1100 → locked=1 again after the third successor.
- Illegal: while locked, drive 0101 → illegal=1, err_count+1, locked=0, idx unchanged. Then 0101 in HUNT → illegal=1, err_count unchanged.
- Saturation, clear, and reset: force 300 LOCKED-state errors → err_count=255. Assert clear_err coincident with an error → err_count=0 and pulse still seen. Assert reset mid-lock → all outputs 0 next cycle and HUNT restarts.
